// File: rtl/getir_kuyruklu_p.sv
// getir_kuyruklu_p
// Parametrised instruction fetch unit. A single line buffer of OBEK_BIT bits
// holds the most recently fetched memory line. 32-bit words are extracted
// from it one per cycle into a KUYRUK_DERINLIK-entry instruction queue. Each
// entry carries its instruction word and PC. Fetch redirects (mispredict,
// mret, jal) are resolved with a fixed priority. A memory request that is
// already in flight when a redirect arrives is drained in IPTAL, and its
// data is never used.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   durdur_i                decode stall, blocks queue pop only
//   dallanma_hata_i/_ps_i   mispredict redirect (priority 1) and target
//   mret_gecerli_i/_ps_i    mret redirect (priority 2) and target
//   jal_gecerli_i/_adres_i  jal redirect (priority 3) and target
//   anabellek_istek_o       line read request
//   anabellek_adres_o       line-aligned request address
//   anabellek_musait_i      memory accepts the request this cycle
//   getir_veri_hazir_i      one-cycle pulse, okunan_obek_i is valid
//   okunan_obek_i           returned line, word k at bits [32k+31:32k]
//   buyruk_gecerli_o        queue head valid
//   buyruk_o, buyruk_ps_o   queue head instruction and PC
//
// Handshakes: a memory request is transferred in any cycle where
// anabellek_istek_o and anabellek_musait_i are both 1. The request then drops
// on the next cycle. Exactly one getir_veri_hazir_i pulse answers each
// accepted request. The queue head is consumed in any cycle where
// buyruk_gecerli_o is 1 and durdur_i is 0.

module getir_kuyruklu_p #(
    parameter int          OBEK_BIT        = 128,
    parameter int          KUYRUK_DERINLIK = 4,
    parameter logic [31:0] BASLANGIC_PS    = 32'h4000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                durdur_i,
    input  logic                dallanma_hata_i,
    input  logic [31:0]         dallanma_ps_i,
    input  logic                mret_gecerli_i,
    input  logic [31:0]         mret_ps_i,
    input  logic                jal_gecerli_i,
    input  logic [31:0]         jal_adres_i,
    output logic                anabellek_istek_o,
    output logic [31:0]         anabellek_adres_o,
    input  logic                anabellek_musait_i,
    input  logic                getir_veri_hazir_i,
    input  logic [OBEK_BIT-1:0] okunan_obek_i,
    output logic                buyruk_gecerli_o,
    output logic [31:0]         buyruk_o,
    output logic [31:0]         buyruk_ps_o
);

    localparam int LB   = $clog2(OBEK_BIT / 8);   // byte offset bits within a line
    localparam int WI   = LB - 2;                 // word index bits
    localparam int QA   = $clog2(KUYRUK_DERINLIK);
    localparam int TAGW = 32 - LB;

    typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, IPTAL} durum_t;

    durum_t              durum_q, durum_d;
    logic [31:0]         ps_q, ps_d;
    logic [OBEK_BIT-1:0] obek_q, obek_d;
    logic [TAGW-1:0]     etiket_q, etiket_d;
    logic                obek_gecerli_q, obek_gecerli_d;
    logic                istek_q, istek_d;
    logic [31:0]         adres_q, adres_d;
    logic [QA-1:0]       oku_q, oku_d, yaz_q, yaz_d;
    logic [QA:0]         sayac_q, sayac_d;

    logic [31:0] buyruk_dizi [KUYRUK_DERINLIK];
    logic [31:0] ps_dizi     [KUYRUK_DERINLIK];

    logic          yonlendir, isabet, dolu, bas_gecerli, push, pop;
    logic [31:0]   hedef_ham, hedef, kelime;
    logic [WI-1:0] kelime_idx;

    always_comb begin
        yonlendir = dallanma_hata_i | mret_gecerli_i | jal_gecerli_i;
        if (dallanma_hata_i)     hedef_ham = dallanma_ps_i;
        else if (mret_gecerli_i) hedef_ham = mret_ps_i;
        else                     hedef_ham = jal_adres_i;
        hedef = hedef_ham & ~32'h3;   // no compressed instructions: force word alignment

        isabet      = obek_gecerli_q && (etiket_q == ps_q[31:LB]);
        dolu        = (sayac_q == (QA+1)'(KUYRUK_DERINLIK));
        bas_gecerli = (sayac_q != '0);
        kelime_idx  = ps_q[LB-1:2];
        kelime      = obek_q[{kelime_idx, 5'b00000} +: 32];

        // A redirect cycle flushes the queue, so neither push nor pop happens in it.
        // A full queue refuses the push even if the head is popped in the same cycle.
        push = !yonlendir && (durum_q == BOSTA) && isabet && !dolu;
        pop  = !yonlendir && bas_gecerli && !durdur_i;

        ps_d           = ps_q;
        durum_d        = durum_q;
        obek_d         = obek_q;
        etiket_d       = etiket_q;
        obek_gecerli_d = obek_gecerli_q;
        oku_d          = oku_q;
        yaz_d          = yaz_q;
        sayac_d        = sayac_q;

        if (yonlendir) begin
            ps_d    = hedef;
            oku_d   = '0;
            yaz_d   = '0;
            sayac_d = '0;
        end else begin
            if (push) begin
                ps_d  = ps_q + 32'd4;
                yaz_d = yaz_q + QA'(1);
            end
            if (pop) oku_d = oku_q + QA'(1);
            if (push && !pop)      sayac_d = sayac_q + (QA+1)'(1);
            else if (!push && pop) sayac_d = sayac_q - (QA+1)'(1);
        end

        case (durum_q)
            BOSTA: if (!yonlendir && !isabet) durum_d = ISTEK;
            // Once accepted, the request is in flight and must be drained.
            ISTEK: if (anabellek_musait_i) durum_d = yonlendir ? IPTAL : BEKLE;
            BEKLE: begin
                if (getir_veri_hazir_i) begin
                    if (yonlendir) begin
                        durum_d = ISTEK;
                    end else begin
                        obek_d         = okunan_obek_i;
                        etiket_d       = ps_q[31:LB];
                        obek_gecerli_d = 1'b1;
                        durum_d        = BOSTA;
                    end
                end else if (yonlendir) begin
                    durum_d = IPTAL;
                end
            end
            IPTAL: if (getir_veri_hazir_i) durum_d = ISTEK;
            default: durum_d = BOSTA;
        endcase

        istek_d = (durum_d == ISTEK);
        adres_d = istek_d ? {ps_d[31:LB], LB'(0)} : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q        <= BOSTA;
            ps_q           <= BASLANGIC_PS;
            obek_q         <= '0;
            etiket_q       <= '0;
            obek_gecerli_q <= 1'b0;
            istek_q        <= 1'b0;
            adres_q        <= 32'h0;
            oku_q          <= '0;
            yaz_q          <= '0;
            sayac_q        <= '0;
        end else begin
            durum_q        <= durum_d;
            ps_q           <= ps_d;
            obek_q         <= obek_d;
            etiket_q       <= etiket_d;
            obek_gecerli_q <= obek_gecerli_d;
            istek_q        <= istek_d;
            adres_q        <= adres_d;
            oku_q          <= oku_d;
            yaz_q          <= yaz_d;
            sayac_q        <= sayac_d;
        end
    end

    // Queue storage needs no reset: the count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buyruk_dizi[yaz_q] <= kelime;
            ps_dizi[yaz_q]     <= ps_q;
        end
    end

    assign anabellek_istek_o = istek_q;
    assign anabellek_adres_o = adres_q;
    assign buyruk_gecerli_o  = bas_gecerli;
    assign buyruk_o          = bas_gecerli ? buyruk_dizi[oku_q] : 32'h0;
    assign buyruk_ps_o       = bas_gecerli ? ps_dizi[oku_q]     : 32'h0;

endmodule

// File: tb/tb_getir_kuyruklu_p.sv
// Directed bench for getir_kuyruklu_p: instance a uses a 128-bit line,
// instance b uses a 256-bit line. Memory words are word_of(byte address).
module tb_getir_kuyruklu_p;

    logic         clk = 1'b0;
    logic         rst;
    logic         durdur, dal, mret, jal;
    logic [31:0]  dal_ps, mret_ps, jal_ps;
    logic         musait_a, hazir_a;
    logic [127:0] obek_a;
    logic         istek_a, gec_a;
    logic [31:0]  adres_a, buy_a, ps_a;
    logic         dal_b, musait_b, hazir_b;
    logic [31:0]  dal_ps_b;
    logic [255:0] obek_b;
    logic         istek_b, gec_b;
    logic [31:0]  adres_b, buy_b, ps_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    getir_kuyruklu_p #(.OBEK_BIT(128), .KUYRUK_DERINLIK(4), .BASLANGIC_PS(32'h4000_0000)) dut_a (
        .clk_i(clk), .rst_i(rst), .durdur_i(durdur),
        .dallanma_hata_i(dal), .dallanma_ps_i(dal_ps),
        .mret_gecerli_i(mret), .mret_ps_i(mret_ps),
        .jal_gecerli_i(jal), .jal_adres_i(jal_ps),
        .anabellek_istek_o(istek_a), .anabellek_adres_o(adres_a),
        .anabellek_musait_i(musait_a), .getir_veri_hazir_i(hazir_a),
        .okunan_obek_i(obek_a),
        .buyruk_gecerli_o(gec_a), .buyruk_o(buy_a), .buyruk_ps_o(ps_a)
    );

    getir_kuyruklu_p #(.OBEK_BIT(256), .KUYRUK_DERINLIK(4), .BASLANGIC_PS(32'h4000_0000)) dut_b (
        .clk_i(clk), .rst_i(rst), .durdur_i(1'b0),
        .dallanma_hata_i(dal_b), .dallanma_ps_i(dal_ps_b),
        .mret_gecerli_i(1'b0), .mret_ps_i(32'h0),
        .jal_gecerli_i(1'b0), .jal_adres_i(32'h0),
        .anabellek_istek_o(istek_b), .anabellek_adres_o(adres_b),
        .anabellek_musait_i(musait_b), .getir_veri_hazir_i(hazir_b),
        .okunan_obek_i(obek_b),
        .buyruk_gecerli_o(gec_b), .buyruk_o(buy_b), .buyruk_ps_o(ps_b)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        durdur = 1'b0; dal = 1'b0; mret = 1'b0; jal = 1'b0;
        dal_ps = 32'h0; mret_ps = 32'h0; jal_ps = 32'h0;
        musait_a = 1'b1; hazir_a = 1'b0; obek_a = '0;
        dal_b = 1'b0; dal_ps_b = 32'h0; musait_b = 1'b0; hazir_b = 1'b0; obek_b = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Memory driver: waits for a request, accepts it, answers after lat cycles.
    task automatic serve(input bit b, input int lat, output logic [31:0] addr);
        int n;
        logic [255:0] line;
        n = 0;
        while (((b ? istek_b : istek_a) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 40) begin
            n_err++;
            $display("FAIL serve_timeout: request=0 after %0d cycles, required 1", n);
            addr = 32'h0;
            return;
        end
        addr = b ? adres_b : adres_a;
        tick();
        repeat (lat - 1) tick();
        for (int k = 0; k < 8; k++) line[32*k +: 32] = word_of(addr + 32'(4*k));
        if (b) begin obek_b = line; hazir_b = 1'b1; end
        else   begin obek_a = line[127:0]; hazir_a = 1'b1; end
        tick();
        hazir_a = 1'b0;
        hazir_b = 1'b0;
    endtask

    task automatic wait_gec_a();
        int n;
        n = 0;
        while (gec_a !== 1'b1 && n < 20) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        durdur = 1'b0; dal = 1'b0; mret = 1'b0; jal = 1'b0;
        musait_a = 1'b1; hazir_a = 1'b0; musait_b = 1'b0; hazir_b = 1'b0;
        dal_b = 1'b0;
        tick();
        n_cmp++;
        if ({istek_a, adres_a, gec_a, buy_a, ps_a} !== 98'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got istek=%b adres=%h gec=%b buy=%h ps=%h, required all 0",
                     istek_a, adres_a, gec_a, buy_a, ps_a);
        end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] addr;
        reset_dut();
        serve(1'b0, 2, addr);
        n_cmp++;
        if (addr !== 32'h4000_0000) begin n_err++; $display("FAIL t1_addr: got %h required 40000000", addr); end
        wait_gec_a();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (gec_a !== 1'b1 || ps_a !== 32'h4000_0000 + 32'(4*k) || buy_a !== word_of(32'h4000_0000 + 32'(4*k))) begin
                n_err++;
                $display("FAIL t1_head%0d: got gec=%b ps=%h buy=%h, required 1 %h %h", k, gec_a, ps_a, buy_a,
                         32'h4000_0000 + 32'(4*k), word_of(32'h4000_0000 + 32'(4*k)));
            end
            tick();
        end
        n_cmp++;
        if (gec_a !== 1'b0 || istek_a !== 1'b1 || adres_a !== 32'h4000_0010) begin
            n_err++;
            $display("FAIL t1_second_req: got gec=%b istek=%b adres=%h, required 0 1 40000010", gec_a, istek_a, adres_a);
        end
    endtask

    // Continues from test_basic_fetch: request for 0x4000_0010 is pending.
    task automatic test_stall_full();
        logic [31:0] addr;
        durdur = 1'b1;
        serve(1'b0, 2, addr);
        serve(1'b0, 2, addr);
        n_cmp++;
        if (addr !== 32'h4000_0020) begin n_err++; $display("FAIL t2_addr: got %h required 40000020", addr); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (gec_a !== 1'b1 || ps_a !== 32'h4000_0010 || buy_a !== word_of(32'h4000_0010) || istek_a !== 1'b0) begin
                n_err++;
                $display("FAIL t2_hold%0d: got gec=%b ps=%h buy=%h istek=%b, required 1 40000010 %h 0",
                         i, gec_a, ps_a, buy_a, istek_a, word_of(32'h4000_0010));
            end
            tick();
        end
        durdur = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (gec_a !== 1'b1 || ps_a !== 32'h4000_0010 + 32'(4*k) || buy_a !== word_of(32'h4000_0010 + 32'(4*k))) begin
                n_err++;
                $display("FAIL t2_pop%0d: got gec=%b ps=%h buy=%h, required 1 %h", k, gec_a, ps_a, buy_a,
                         32'h4000_0010 + 32'(4*k));
            end
            tick();
        end
    endtask

    task automatic test_redirect_priority();
        logic [31:0] addr;
        reset_dut();
        durdur = 1'b1;
        serve(1'b0, 1, addr);
        musait_a = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (gec_a !== 1'b1 || ps_a !== 32'h4000_0000 || istek_a !== 1'b1 || adres_a !== 32'h4000_0010) begin
            n_err++;
            $display("FAIL t3_pre: got gec=%b ps=%h istek=%b adres=%h, required 1 40000000 1 40000010",
                     gec_a, ps_a, istek_a, adres_a);
        end
        dal = 1'b1; dal_ps = 32'h4000_0102; jal = 1'b1; jal_ps = 32'h4000_0200;
        tick();
        dal = 1'b0; jal = 1'b0;
        n_cmp++;
        if (gec_a !== 1'b0 || istek_a !== 1'b1 || adres_a !== 32'h4000_0100) begin
            n_err++;
            $display("FAIL t3_flush: got gec=%b istek=%b adres=%h, required 0 1 40000100", gec_a, istek_a, adres_a);
        end
        musait_a = 1'b1;
        durdur = 1'b0;
        serve(1'b0, 1, addr);
        wait_gec_a();
        n_cmp++;
        if (gec_a !== 1'b1 || ps_a !== 32'h4000_0100 || buy_a !== word_of(32'h4000_0100)) begin
            n_err++;
            $display("FAIL t3_first: got gec=%b ps=%h buy=%h, required 1 40000100 %h", gec_a, ps_a, buy_a,
                     word_of(32'h4000_0100));
        end
        mret = 1'b1; mret_ps = 32'h4000_0008; jal = 1'b1; jal_ps = 32'h4000_0200;
        tick();
        mret = 1'b0; jal = 1'b0;
        n_cmp++;
        if (gec_a !== 1'b0) begin n_err++; $display("FAIL t3_mret_flush: got gec=%b required 0", gec_a); end
        serve(1'b0, 1, addr);
        n_cmp++;
        if (addr !== 32'h4000_0000) begin n_err++; $display("FAIL t3_mret_addr: got %h required 40000000", addr); end
        wait_gec_a();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (gec_a !== 1'b1 || ps_a !== 32'h4000_0008 + 32'(4*k) || buy_a !== word_of(32'h4000_0008 + 32'(4*k))) begin
                n_err++;
                $display("FAIL t3_mret_head%0d: got gec=%b ps=%h buy=%h, required 1 %h", k, gec_a, ps_a, buy_a,
                         32'h4000_0008 + 32'(4*k));
            end
            tick();
        end
    endtask

    task automatic test_redirect_in_flight();
        logic [31:0] addr;
        int n;
        reset_dut();
        n = 0;
        while (istek_a !== 1'b1 && n < 10) begin tick(); n++; end
        tick();
        dal = 1'b1; dal_ps = 32'h4000_0300;
        tick();
        dal = 1'b0;
        n_cmp++;
        if (istek_a !== 1'b0 || gec_a !== 1'b0) begin
            n_err++;
            $display("FAIL t4_cancel: got istek=%b gec=%b, required 0 0", istek_a, gec_a);
        end
        for (int k = 0; k < 4; k++) obek_a[32*k +: 32] = word_of(32'h4000_0000 + 32'(4*k));
        hazir_a = 1'b1;
        tick();
        hazir_a = 1'b0;
        n_cmp++;
        if (istek_a !== 1'b1 || adres_a !== 32'h4000_0300 || gec_a !== 1'b0) begin
            n_err++;
            $display("FAIL t4_rerequest: got istek=%b adres=%h gec=%b, required 1 40000300 0", istek_a, adres_a, gec_a);
        end
        serve(1'b0, 2, addr);
        n_cmp++;
        if (gec_a !== 1'b0) begin n_err++; $display("FAIL t4_no_stale: got gec=%b required 0", gec_a); end
        wait_gec_a();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (gec_a !== 1'b1 || ps_a !== 32'h4000_0300 + 32'(4*k) || buy_a !== word_of(32'h4000_0300 + 32'(4*k))) begin
                n_err++;
                $display("FAIL t4_head%0d: got gec=%b ps=%h buy=%h, required 1 %h %h", k, gec_a, ps_a, buy_a,
                         32'h4000_0300 + 32'(4*k), word_of(32'h4000_0300 + 32'(4*k)));
            end
            tick();
        end
    endtask

    task automatic test_wide_line();
        logic [31:0] addr;
        int n;
        reset_dut();
        tick();
        dal_b = 1'b1; dal_ps_b = 32'h4000_001C;
        tick();
        dal_b = 1'b0;
        n_cmp++;
        if (istek_b !== 1'b1 || adres_b !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL t5_req: got istek=%b adres=%h, required 1 40000000", istek_b, adres_b);
        end
        musait_b = 1'b1;
        serve(1'b1, 1, addr);
        n_cmp++;
        if (istek_b !== 1'b0) begin n_err++; $display("FAIL t5_single_req: got istek=%b required 0", istek_b); end
        n = 0;
        while (gec_b !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++;
        if (gec_b !== 1'b1 || ps_b !== 32'h4000_001C || buy_b !== word_of(32'h4000_001C)) begin
            n_err++;
            $display("FAIL t5_word7: got gec=%b ps=%h buy=%h, required 1 4000001c %h", gec_b, ps_b, buy_b,
                     word_of(32'h4000_001C));
        end
        tick();
        n_cmp++;
        if (gec_b !== 1'b0 || istek_b !== 1'b1 || adres_b !== 32'h4000_0020) begin
            n_err++;
            $display("FAIL t5_next_req: got gec=%b istek=%b adres=%h, required 0 1 40000020", gec_b, istek_b, adres_b);
        end
    endtask

    task automatic test_reset_mid_request();
        logic [31:0] addr;
        int n;
        reset_dut();
        durdur = 1'b1;
        serve(1'b0, 1, addr);
        n = 0;
        while (istek_a !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        n_cmp++;
        if (gec_a !== 1'b1 || istek_a !== 1'b0) begin
            n_err++;
            $display("FAIL t6_pre: got gec=%b istek=%b, required 1 0", gec_a, istek_a);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({istek_a, adres_a, gec_a, buy_a, ps_a} !== 98'h0) begin
            n_err++;
            $display("FAIL t6_async_zero: got istek=%b adres=%h gec=%b buy=%h ps=%h, required all 0",
                     istek_a, adres_a, gec_a, buy_a, ps_a);
        end
        tick();
        rst = 1'b0;
        durdur = 1'b0;
        obek_a = {4{32'hDEAD_BEEF}};
        hazir_a = 1'b1;
        tick();
        hazir_a = 1'b0;
        n_cmp++;
        if (istek_a !== 1'b1 || adres_a !== 32'h4000_0000 || gec_a !== 1'b0) begin
            n_err++;
            $display("FAIL t6_refetch_req: got istek=%b adres=%h gec=%b, required 1 40000000 0", istek_a, adres_a, gec_a);
        end
        serve(1'b0, 1, addr);
        wait_gec_a();
        n_cmp++;
        if (gec_a !== 1'b1 || ps_a !== 32'h4000_0000 || buy_a !== word_of(32'h4000_0000)) begin
            n_err++;
            $display("FAIL t6_refetch_head: got gec=%b ps=%h buy=%h, required 1 40000000 %h", gec_a, ps_a, buy_a,
                     word_of(32'h4000_0000));
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_full();
        test_redirect_priority();
        test_redirect_in_flight();
        test_wide_line();
        test_reset_mid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
